// File: rtl/mips_pkg.sv
// Shared opcode constants and fetch FSM state type for the MIPS-subset pipeline.
package mips_pkg;

   localparam int unsigned OPC_W = 6;

   localparam logic [OPC_W-1:0] OPC_AND  = 6'h00;
   localparam logic [OPC_W-1:0] OPC_OR   = 6'h01;
   localparam logic [OPC_W-1:0] OPC_ADD  = 6'h02;
   localparam logic [OPC_W-1:0] OPC_SUB  = 6'h06;
   localparam logic [OPC_W-1:0] OPC_SLT  = 6'h07;
   localparam logic [OPC_W-1:0] OPC_LW   = 6'h08;
   localparam logic [OPC_W-1:0] OPC_SW   = 6'h0A;
   localparam logic [OPC_W-1:0] OPC_BNE  = 6'h0E;
   localparam logic [OPC_W-1:0] OPC_HALT = 6'h3F;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Flush clears valid and the instruction word but keeps pc_plus4.
module ifid_reg
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic [31:0]       instr_in,
   input  logic [ADDR_W-1:0] pc_plus4_in,
   output logic              valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc_plus4
);

   logic              valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] pc_plus4_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
      end else if (load) begin
         valid_q    <= 1'b1;
         instr_q    <= instr_in;
         pc_plus4_q <= pc_plus4_in;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT FSM and IF/ID register feeding decode.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned      ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [OPC_W-1:0]  HALT_OP  = OPC_HALT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              ifid_valid,
   output logic [31:0]       ifid_instr,
   output logic [5:0]        ifid_opcode,
   output logic [ADDR_W-1:0] ifid_pc_plus4,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] target;
   logic              is_halt;
   logic              ifid_load;
   logic              ifid_flush;

   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign target   = branch_target & ~(ADDR_W'(3));
   assign is_halt  = (opcode_of(imem_rdata) == HALT_OP);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (branch_taken) begin
               pc_d       = target;
               ifid_flush = 1'b1;
            end else if (!stall) begin
               ifid_load = 1'b1;
               if (is_halt) begin
                  state_d = HALT;
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         HALT: begin
            // A late redirect means the HALT was on a wrong path; resume there.
            if (branch_taken) begin
               pc_d       = target;
               ifid_flush = 1'b1;
               state_d    = RUN;
            end else if (!stall) begin
               ifid_flush = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifid_reg #(
      .ADDR_W (ADDR_W)
   ) u_ifid_reg (
      .clk         (clk),
      .rst         (rst),
      .load        (ifid_load),
      .flush       (ifid_flush),
      .instr_in    (imem_rdata),
      .pc_plus4_in (pc_plus4),
      .valid       (ifid_valid),
      .instr       (ifid_instr),
      .pc_plus4    (ifid_pc_plus4)
   );

   assign imem_addr   = pc_q;
   assign ifid_opcode = ifid_instr[31:26];
   assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_flushed_q;

   // Counting only in RUN keeps both counters frozen while halted.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else if (state_q == RUN) begin
         if (ifid_load) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (branch_taken && ifid_valid) begin
            perf_flushed_q <= perf_flushed_q + 32'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, straight-line fetch, stall, branch, halt and PC wrap.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [5:0]  ifid_opcode;
   logic [31:0] ifid_pc_plus4;
   logic        halted;

   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_ifid_valid;
   logic [31:0] w_ifid_instr;
   logic [5:0]  w_ifid_opcode;
   logic [31:0] w_ifid_pc_plus4;
   logic        w_halted;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

   logic [31:0] mem [64];

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [31:0] I_ADD = 32'h0822_1800;
   localparam logic [31:0] I_OR  = 32'h0443_2000;
   localparam logic [31:0] I_SUB = 32'h1864_2800;
   localparam logic [31:0] I_SLT = 32'h1C85_3000;
   localparam logic [31:0] I_SW  = 32'h2800_0020;
   localparam logic [31:0] I_LW  = 32'h2000_0010;

   assign imem_rdata   = mem[imem_addr[7:2]];
   // Wrap instance memory: ADD opcode tagged with the low address byte.
   assign w_imem_rdata = {6'h02, 18'h0, w_imem_addr[7:0]};

   fetch_stage u_dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_opcode   (ifid_opcode),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_flushed  (perf_flushed)
`endif
   );

   fetch_stage #(
      .RESET_PC (32'hFFFF_FFF8)
   ) u_wrap (
      .clk           (clk),
      .rst           (rst),
      .stall         (1'b0),
      .branch_taken  (1'b0),
      .branch_target (32'h0),
      .imem_addr     (w_imem_addr),
      .imem_rdata    (w_imem_rdata),
      .ifid_valid    (w_ifid_valid),
      .ifid_instr    (w_ifid_instr),
      .ifid_opcode   (w_ifid_opcode),
      .ifid_pc_plus4 (w_ifid_pc_plus4),
      .halted        (w_halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (w_perf_fetched),
      .perf_flushed  (w_perf_flushed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0]  = I_ADD;
      mem[1]  = I_OR;
      mem[2]  = I_SUB;
      mem[3]  = I_SLT;
      mem[8]  = I_SW;
      mem[16] = I_LW;

      // Reset
      tick();
      tick();
      chk("rst_valid", ifid_valid, 0);
      chk("rst_instr", ifid_instr, 0);
      chk("rst_pc4", ifid_pc_plus4, 0);
      chk("rst_halted", halted, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
      rst = 1'b0;

      tick();  // BOOT -> RUN, PC held
      chk("boot_addr", imem_addr, 0);
      chk("boot_valid", ifid_valid, 0);
      chk("boot_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
      chk("boot_wrap_valid", w_ifid_valid, 0);

      tick();
      chk("f0_addr", imem_addr, 4);
      chk("f0_valid", ifid_valid, 1);
      chk("f0_instr", ifid_instr, I_ADD);
      chk("f0_pc4", ifid_pc_plus4, 4);
      chk("f0_opcode", ifid_opcode, 6'h02);
      chk("wrap_f8_addr", w_imem_addr, 32'hFFFF_FFFC);
      chk("wrap_f8_instr", w_ifid_instr, 32'h0800_00F8);
      chk("wrap_f8_pc4", w_ifid_pc_plus4, 32'hFFFF_FFFC);

      tick();
      chk("f1_opcode", ifid_opcode, 6'h01);
      chk("f1_pc4", ifid_pc_plus4, 8);
      chk("f1_addr", imem_addr, 8);
      chk("wrap_fc_addr", w_imem_addr, 32'h0);
      chk("wrap_fc_instr", w_ifid_instr, 32'h0800_00FC);
      chk("wrap_fc_pc4", w_ifid_pc_plus4, 32'h0);

      // Stall three cycles at pc=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_addr", imem_addr, 8);
         chk("stall_instr", ifid_instr, I_OR);
      end
      stall = 1'b0;

      tick();
      chk("f2_opcode", ifid_opcode, 6'h06);
      chk("f2_addr", imem_addr, 12);
      chk("f2_pc4", ifid_pc_plus4, 12);

      tick();
      chk("f3_opcode", ifid_opcode, 6'h07);
      chk("f3_addr", imem_addr, 16);

      // Branch beats stall; target low bits dropped
      branch_taken  = 1'b1;
      branch_target = 32'h43;
      stall         = 1'b1;
      tick();
      chk("br_addr", imem_addr, 32'h40);
      chk("br_valid", ifid_valid, 0);
      chk("br_instr", ifid_instr, 0);
      branch_taken = 1'b0;
      stall        = 1'b0;

      tick();
      chk("br_load_instr", ifid_instr, I_LW);
      chk("br_load_pc4", ifid_pc_plus4, 32'h44);
      chk("br_load_addr", imem_addr, 32'h44);

      // Halt: redirect to 8 so the HALT word at 12 is fetched
      mem[3]        = 32'hFC00_0000;
      branch_taken  = 1'b1;
      branch_target = 32'h0A;
      tick();
      chk("h_br_addr", imem_addr, 8);
      chk("h_br_valid", ifid_valid, 0);
      branch_taken = 1'b0;

      tick();
      chk("h_pre_opcode", ifid_opcode, 6'h06);
      chk("h_pre_addr", imem_addr, 12);

      tick();
      chk("h_opcode", ifid_opcode, 6'h3F);
      chk("h_valid", ifid_valid, 1);
      chk("h_halted", halted, 1);
      chk("h_addr", imem_addr, 12);
      chk("h_pc4", ifid_pc_plus4, 16);

      tick();
      chk("h_bub_valid", ifid_valid, 0);
      chk("h_bub_instr", ifid_instr, 0);
      chk("h_bub_pc4", ifid_pc_plus4, 16);
      chk("h_bub_halted", halted, 1);
      chk("h_bub_addr", imem_addr, 12);

      for (int i = 0; i < 10; i++) begin
         stall = i[0];
         tick();
         chk("h_idle_addr", imem_addr, 12);
         chk("h_idle_valid", ifid_valid, 0);
         chk("h_idle_halted", halted, 1);
      end
      stall = 1'b0;

      branch_taken  = 1'b1;
      branch_target = 32'h20;
      tick();
      chk("h_exit_addr", imem_addr, 32'h20);
      chk("h_exit_halted", halted, 0);
      chk("h_exit_valid", ifid_valid, 0);
      branch_taken = 1'b0;

      tick();
      chk("h_exit_opcode", ifid_opcode, 6'h0A);
      chk("h_exit_instr", ifid_instr, I_SW);
      chk("h_exit_pc4", ifid_pc_plus4, 32'h24);
      chk("h_exit_addr2", imem_addr, 32'h24);

      // Reset mid-operation beats branch and stall
      rst           = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h80;
      stall         = 1'b1;
      tick();
      chk("mrst_addr", imem_addr, 0);
      chk("mrst_valid", ifid_valid, 0);
      chk("mrst_instr", ifid_instr, 0);
      chk("mrst_pc4", ifid_pc_plus4, 0);
      chk("mrst_halted", halted, 0);
      rst          = 1'b0;
      branch_taken = 1'b0;
      stall        = 1'b0;

      tick();
      chk("mrst_boot_addr", imem_addr, 0);
      chk("mrst_boot_valid", ifid_valid, 0);

      tick();
      chk("mrst_f0_instr", ifid_instr, I_ADD);
      chk("mrst_f0_addr", imem_addr, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
